// File: rtl/jzjpcc_pkg.sv
// Shared types for the jzjpcc decode->execute boundary: ALU operand-mux select
// encoding and the bundle of fields latched into the execute stage.
package jzjpcc_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    ALU_RS1_RS2 = 2'b00,
    ALU_RS1_IMM = 2'b01,
    ALU_PC_4    = 2'b10,
    ALU_PC_IMM  = 2'b11
  } aluMuxMode_t;

  // PC is sized by the top-level parameter, so it lives beside this bundle.
  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       rs1;
    logic [XLEN-1:0]       rs2;
    logic [XLEN-1:0]       immediate;
    aluMuxMode_t           aluMuxMode;
    logic [REG_ADDR_W-1:0] rdAddr;
    logic                  rdWriteEnable;
    logic                  isLoad;
  } idex_bundle_t;

  localparam idex_bundle_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/jzjpcc_loaduse_detect.sv
// Combinational load-use hazard term: the load sitting in execute writes a
// register that the valid instruction in decode is about to read.
module jzjpcc_loaduse_detect
  import jzjpcc_pkg::*;
(
  input  logic                  executeValid,
  input  logic                  executeIsLoad,
  input  logic                  executeRdWriteEnable,
  input  logic [REG_ADDR_W-1:0] executeRdAddr,
  input  logic                  decodeValid,
  input  logic                  decodeUsesRs1,
  input  logic [REG_ADDR_W-1:0] decodeRs1Addr,
  input  logic                  decodeUsesRs2,
  input  logic [REG_ADDR_W-1:0] decodeRs2Addr,
  output logic                  hazard
);

  logic w_loadInFlight;
  logic w_rs1Match;
  logic w_rs2Match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign w_loadInFlight = executeValid & executeIsLoad & executeRdWriteEnable
                        & (executeRdAddr != '0);
  assign w_rs1Match     = decodeUsesRs1 & (decodeRs1Addr == executeRdAddr);
  assign w_rs2Match     = decodeUsesRs2 & (decodeRs2Addr == executeRdAddr);
  assign hazard         = w_loadInFlight & decodeValid & (w_rs1Match | w_rs2Match);

endmodule

// File: rtl/jzjpcc_idex_register.sv
// Decode->execute pipeline register with load-use bubble insertion, memory
// stall hold and branch flush.
module jzjpcc_idex_register
  import jzjpcc_pkg::*;
#(
  parameter int PC_MAX_B = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  decodeValid,
  input  logic [XLEN-1:0]       decodeRs1Data,
  input  logic [XLEN-1:0]       decodeRs2Data,
  input  logic [XLEN-1:0]       decodeImmediate,
  input  logic [PC_MAX_B:2]     decodePC,
  input  logic [1:0]            decodeAluMuxMode,
  input  logic [REG_ADDR_W-1:0] decodeRs1Addr,
  input  logic [REG_ADDR_W-1:0] decodeRs2Addr,
  input  logic                  decodeUsesRs1,
  input  logic                  decodeUsesRs2,
  input  logic [REG_ADDR_W-1:0] decodeRdAddr,
  input  logic                  decodeRdWriteEnable,
  input  logic                  decodeIsLoad,
  input  logic                  externalStall,
  input  logic                  flushExecute,
  output logic [XLEN-1:0]       rs1,
  output logic [XLEN-1:0]       rs2,
  output logic [XLEN-1:0]       immediate,
  output logic [PC_MAX_B:2]     currentPC,
  output logic [1:0]            aluMuxMode,
  output logic [REG_ADDR_W-1:0] rdAddr,
  output logic                  rdWriteEnable,
  output logic                  isLoad,
  output logic                  executeValid,
  output logic                  stallDecode
);

  idex_bundle_t         r_ex_p1;
  logic [PC_MAX_B:2]    r_pc_p1;
  idex_bundle_t         w_capture;
  logic                 w_hazard;

  jzjpcc_loaduse_detect u_loaduse (
    .executeValid         (r_ex_p1.valid),
    .executeIsLoad        (r_ex_p1.isLoad),
    .executeRdWriteEnable (r_ex_p1.rdWriteEnable),
    .executeRdAddr        (r_ex_p1.rdAddr),
    .decodeValid          (decodeValid),
    .decodeUsesRs1        (decodeUsesRs1),
    .decodeRs1Addr        (decodeRs1Addr),
    .decodeUsesRs2        (decodeUsesRs2),
    .decodeRs2Addr        (decodeRs2Addr),
    .hazard               (w_hazard)
  );

  always_comb begin
    w_capture               = IDEX_BUBBLE;
    w_capture.valid         = 1'b1;
    w_capture.rs1           = decodeRs1Data;
    w_capture.rs2           = decodeRs2Data;
    w_capture.immediate     = decodeImmediate;
    w_capture.aluMuxMode    = aluMuxMode_t'(decodeAluMuxMode);
    w_capture.rdAddr        = decodeRdAddr;
    w_capture.rdWriteEnable = decodeRdWriteEnable;
    w_capture.isLoad        = decodeIsLoad;
  end

  // Decode -> execute boundary. A flush or stall request is held by its source,
  // so while externalStall is high nothing moves and nothing is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ex_p1 <= IDEX_BUBBLE;
      r_pc_p1 <= '0;
    end else if (!externalStall) begin
      if (flushExecute || w_hazard || !decodeValid) begin
        r_ex_p1 <= IDEX_BUBBLE;
        r_pc_p1 <= '0;
      end else begin
        r_ex_p1 <= w_capture;
        r_pc_p1 <= decodePC;
      end
    end
  end

  assign rs1           = r_ex_p1.rs1;
  assign rs2           = r_ex_p1.rs2;
  assign immediate     = r_ex_p1.immediate;
  assign currentPC     = r_pc_p1;
  assign aluMuxMode    = r_ex_p1.aluMuxMode;
  assign rdAddr        = r_ex_p1.rdAddr;
  assign rdWriteEnable = r_ex_p1.rdWriteEnable;
  assign isLoad        = r_ex_p1.isLoad;
  assign executeValid  = r_ex_p1.valid;
  // A flush discards the dependent instruction anyway, so decode need not hold.
  assign stallDecode   = externalStall | (w_hazard & ~flushExecute);

endmodule

// File: tb/tb_jzjpcc_idex_register.sv
// Scoreboard bench for jzjpcc_idex_register: directed instruction sequences
// push expected execute-stage state and stallDecode; monitors pop and compare.
module tb_jzjpcc_idex_register;

  localparam int PC_MAX_B = 15;

  logic                clock = 1'b0;
  logic                reset;
  logic                decodeValid;
  logic [31:0]         decodeRs1Data, decodeRs2Data, decodeImmediate;
  logic [PC_MAX_B:2]   decodePC;
  logic [1:0]          decodeAluMuxMode;
  logic [4:0]          decodeRs1Addr, decodeRs2Addr, decodeRdAddr;
  logic                decodeUsesRs1, decodeUsesRs2, decodeRdWriteEnable, decodeIsLoad;
  logic                externalStall, flushExecute;
  logic [31:0]         rs1, rs2, immediate;
  logic [PC_MAX_B:2]   currentPC;
  logic [1:0]          aluMuxMode;
  logic [4:0]          rdAddr;
  logic                rdWriteEnable, isLoad, executeValid, stallDecode;

  jzjpcc_idex_register #(.PC_MAX_B(PC_MAX_B)) dut (
    .clock(clock), .reset(reset), .decodeValid(decodeValid),
    .decodeRs1Data(decodeRs1Data), .decodeRs2Data(decodeRs2Data),
    .decodeImmediate(decodeImmediate), .decodePC(decodePC),
    .decodeAluMuxMode(decodeAluMuxMode), .decodeRs1Addr(decodeRs1Addr),
    .decodeRs2Addr(decodeRs2Addr), .decodeUsesRs1(decodeUsesRs1),
    .decodeUsesRs2(decodeUsesRs2), .decodeRdAddr(decodeRdAddr),
    .decodeRdWriteEnable(decodeRdWriteEnable), .decodeIsLoad(decodeIsLoad),
    .externalStall(externalStall), .flushExecute(flushExecute),
    .rs1(rs1), .rs2(rs2), .immediate(immediate), .currentPC(currentPC),
    .aluMuxMode(aluMuxMode), .rdAddr(rdAddr), .rdWriteEnable(rdWriteEnable),
    .isLoad(isLoad), .executeValid(executeValid), .stallDecode(stallDecode)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic v; logic [31:0] rs1d, rs2d, imm; logic [PC_MAX_B:2] pc; logic [1:0] mode;
    logic [4:0] a1; logic u1; logic [4:0] a2; logic u2; logic [4:0] rd; logic we, ld;
  } dec_t;

  typedef struct packed {
    logic v; logic [31:0] rs1, rs2, imm; logic [PC_MAX_B:2] pc; logic [1:0] mode;
    logic [4:0] rd; logic we, ld;
  } exp_t;

  typedef struct { string name; exp_t e; } out_item_t;
  typedef struct { string name; logic s; } stall_item_t;

  out_item_t   outq[$];
  stall_item_t stq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        BUB = '0;

  function automatic dec_t mk(logic v, logic [31:0] r1, logic [31:0] r2, logic [31:0] im,
                              logic [15:0] pcb, logic [1:0] m, logic [4:0] a1, logic u1,
                              logic [4:0] a2, logic u2, logic [4:0] rd, logic we, logic ld);
    dec_t d;
    d.v = v; d.rs1d = r1; d.rs2d = r2; d.imm = im; d.pc = pcb[15:2]; d.mode = m;
    d.a1 = a1; d.u1 = u1; d.a2 = a2; d.u2 = u2; d.rd = rd; d.we = we; d.ld = ld;
    return d;
  endfunction

  function automatic exp_t cap(dec_t d);
    exp_t e;
    e.v = 1'b1; e.rs1 = d.rs1d; e.rs2 = d.rs2d; e.imm = d.imm; e.pc = d.pc;
    e.mode = d.mode; e.rd = d.rd; e.we = d.we; e.ld = d.ld;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t e;
    e.v = executeValid; e.rs1 = rs1; e.rs2 = rs2; e.imm = immediate; e.pc = currentPC;
    e.mode = aluMuxMode; e.rd = rdAddr; e.we = rdWriteEnable; e.ld = isLoad;
    return e;
  endfunction

  task automatic check_out(input string name, input exp_t got, input exp_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b required %b", name, got, want);
  endtask

  task automatic drive(input dec_t d, input logic st, input logic fl);
    decodeValid = d.v; decodeRs1Data = d.rs1d; decodeRs2Data = d.rs2d;
    decodeImmediate = d.imm; decodePC = d.pc; decodeAluMuxMode = d.mode;
    decodeRs1Addr = d.a1; decodeUsesRs1 = d.u1; decodeRs2Addr = d.a2; decodeUsesRs2 = d.u2;
    decodeRdAddr = d.rd; decodeRdWriteEnable = d.we; decodeIsLoad = d.ld;
    externalStall = st; flushExecute = fl;
  endtask

  // Inputs for one cycle; stallDecode is checked this cycle, outputs after the edge.
  task automatic step(input string name, input dec_t d, input logic st, input logic fl,
                      input logic exp_sd, input exp_t e);
    @(posedge clock);
    #2;
    drive(d, st, fl);
    stq.push_back('{name, exp_sd});
    outq.push_back('{name, e});
  endtask

  always @(posedge clock) begin : out_monitor
    out_item_t it;
    #1;
    if (outq.size() > 0) begin
      it = outq.pop_front();
      check_out({"out_", it.name}, observed(), it.e);
    end
  end

  always @(negedge clock) begin : stall_monitor
    stall_item_t it;
    if (stq.size() > 0) begin
      it = stq.pop_front();
      check_bit({"stallDecode_", it.name}, stallDecode, it.s);
    end
  end

  initial begin
    dec_t idle, addi1, lw3, add4, lw0, add40, lw5, add6, addi7, other, jal;
    dec_t lw8, add9, nv, addi1b, post;
    //          v  rs1d          rs2d          imm           pc       mode  a1 u1 a2 u2 rd we ld
    idle   = mk(0, 0,            0,            0,            16'h0,   2'b00, 0, 0, 0, 0, 0, 0, 0);
    addi1  = mk(1, 0,            32'h0000_0077, 5,           16'h40,  2'b01, 0, 1, 5, 0, 1, 1, 0);
    lw3    = mk(1, 32'h100,      0,            8,            16'h44,  2'b01, 2, 1, 0, 0, 3, 1, 1);
    add4   = mk(1, 32'hAAAA,     32'h100,      0,            16'h48,  2'b00, 3, 1, 2, 1, 4, 1, 0);
    lw0    = mk(1, 32'h100,      0,            0,            16'h4C,  2'b01, 2, 1, 0, 0, 0, 1, 1);
    add40  = mk(1, 0,            32'h100,      0,            16'h50,  2'b00, 0, 1, 2, 1, 4, 1, 0);
    lw5    = mk(1, 32'h200,      0,            4,            16'h54,  2'b01, 2, 1, 0, 0, 5, 1, 1);
    add6   = mk(1, 32'h1234,     32'h5,        0,            16'h58,  2'b00, 5, 1, 1, 1, 6, 1, 0);
    addi7  = mk(1, 32'h10,       0,            32'hFFFF_FFF0, 16'h5C, 2'b01, 1, 1, 0, 0, 7, 1, 0);
    other  = mk(1, 32'h3,        32'h4,        0,            16'h70,  2'b00, 3, 1, 4, 1, 10, 1, 0);
    jal    = mk(1, 0,            0,            32'h20,       16'h60,  2'b10, 0, 0, 0, 0, 1, 1, 0);
    lw8    = mk(1, 32'h300,      0,            12,           16'h64,  2'b01, 2, 1, 0, 0, 8, 1, 1);
    add9   = mk(1, 32'hBEEF,     32'h7,        0,            16'h68,  2'b00, 8, 1, 7, 1, 9, 1, 0);
    nv     = mk(0, 32'hDEAD,     32'hBEEF,     32'h55,       16'h6C,  2'b11, 9, 1, 9, 1, 9, 1, 1);
    addi1b = mk(1, 32'h1,        0,            32'h7FF,      16'h74,  2'b01, 1, 1, 0, 0, 1, 1, 0);
    post   = mk(1, 32'h2,        0,            32'hFFFF_FFFF, 16'h80, 2'b11, 2, 1, 0, 0, 2, 1, 0);

    reset = 1'b1;
    drive(idle, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check_out("reset_init", observed(), BUB);
    check_bit("reset_init_stall", stallDecode, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    step("addi_x1",      addi1, 0, 0, 0, cap(addi1));
    step("lw_x3",        lw3,   0, 0, 0, cap(lw3));
    step("add_hazard",   add4,  0, 0, 1, BUB);
    step("add_enters",   add4,  0, 0, 0, cap(add4));
    step("lw_x0",        lw0,   0, 0, 0, cap(lw0));
    step("add_after_x0", add40, 0, 0, 0, cap(add40));
    step("lw_x5",        lw5,   0, 0, 0, cap(lw5));
    step("flush_hazard", add6,  0, 1, 0, BUB);
    step("addi_x7",      addi7, 0, 0, 0, cap(addi7));
    step("flush_stall",  other, 1, 1, 1, cap(addi7));
    for (int i = 0; i < 3; i++)
      step("jal_stalled", jal, 1, 0, 1, cap(addi7));
    step("jal_release",  jal,   0, 0, 0, cap(jal));
    step("lw_x8",        lw8,   0, 0, 0, cap(lw8));
    step("hazard_in_stall", add9, 1, 0, 1, cap(lw8));
    step("hazard_after_stall", add9, 0, 0, 1, BUB);
    step("add_x9",       add9,  0, 0, 0, cap(add9));
    step("decode_invalid", nv,  0, 0, 0, BUB);
    step("addi_x1b",     addi1b, 0, 0, 0, cap(addi1b));

    // Asynchronous reset between edges while a valid instruction sits in execute.
    @(posedge clock);
    #3;
    drive(post, 0, 0);
    reset = 1'b1;
    #1;
    check_out("reset_mid", observed(), BUB);
    reset = 1'b0;
    stq.push_back('{"post_reset", 1'b0});
    outq.push_back('{"post_reset", cap(post)});

    repeat (3) @(posedge clock);
    #3;
    if (outq.size() != 0 || stq.size() != 0) begin
      n_checks++;
      $display("FAIL drain: pending out=%0d stall=%0d required 0", outq.size(), stq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
